// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send, shifts one byte
// out on device clock falls and checks the ACK bit.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYC = 2500,
    parameter int unsigned START_TO    = 375000,
    parameter int unsigned PKT_TO      = 50000,
    parameter int unsigned FILT        = 8
) (
    input  logic       mclk,
    input  logic       reset_in,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic       rx_inhibit
);

    localparam int unsigned MAX_AB  = (INHIBIT_CYC > START_TO) ? INHIBIT_CYC : START_TO;
    localparam int unsigned TMR_MAX = (MAX_AB > PKT_TO) ? MAX_AB : PKT_TO;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned FW      = (FILT > 1) ? $clog2(FILT + 1) : 1;

    localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INHIBIT_CYC - 1);
    localparam logic [TMR_W-1:0] STO_LAST = TMR_W'(START_TO - 1);
    localparam logic [TMR_W-1:0] PKT_LAST = TMR_W'(PKT_TO - 1);
    localparam logic [FW-1:0]    FLT_LAST = FW'(FILT - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StInhibit = 3'd1;
    localparam logic [2:0] StReq     = 3'd2;
    localparam logic [2:0] StShift   = 3'd3;
    localparam logic [2:0] StAck     = 3'd4;
    localparam logic [2:0] StRecover = 3'd5;

    // Index 0 is the clock line, index 1 the data line.
    logic [1:0]    meta_q, sync_q, filt_q;
    logic [FW-1:0] fcnt_q [2];
    logic          clk_prev_q;
    logic          fall;

    always_ff @(posedge mclk) begin
        if (reset_in) begin
            meta_q     <= 2'b11;
            sync_q     <= 2'b11;
            filt_q     <= 2'b11;
            fcnt_q[0]  <= '0;
            fcnt_q[1]  <= '0;
            clk_prev_q <= 1'b1;
        end else begin
            meta_q     <= {ps2_data_i, ps2_clk_i};
            sync_q     <= meta_q;
            clk_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FLT_LAST) begin
                    filt_q[i] <= sync_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign fall = clk_prev_q & ~filt_q[0];

    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d, tmr_inc;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
    logic             out_bit_q, out_bit_d;
    logic             ok_q, ok_d;
    logic             lines_idle;

    assign tmr_inc    = (&tmr_q) ? tmr_q : tmr_q + 1'b1;
    assign lines_idle = &filt_q;

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_d     = par_q;
        out_bit_d = out_bit_q;
        ok_d      = ok_q;
        unique case (state_q)
            StIdle: begin
                if (tx_wr) begin
                    data_d  = tx_data;
                    par_d   = ~^tx_data;
                    tmr_d   = '0;
                    ok_d    = 1'b0;
                    state_d = StInhibit;
                end
            end
            StInhibit: begin
                if (tmr_q >= INH_LAST) begin
                    tmr_d   = '0;
                    state_d = StReq;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            StReq: begin
                if (fall) begin
                    tmr_d     = '0;
                    bit_cnt_d = '0;
                    out_bit_d = 1'b0;
                    state_d   = StShift;
                end else if (tmr_q >= STO_LAST) begin
                    ok_d    = 1'b0;
                    state_d = StRecover;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            StShift: begin
                if (tmr_q >= PKT_LAST) begin
                    ok_d    = 1'b0;
                    state_d = StRecover;
                end else begin
                    tmr_d = tmr_inc;
                    if (fall) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q < 4'd8) begin
                            out_bit_d = data_q[bit_cnt_q[2:0]];
                        end else if (bit_cnt_q == 4'd8) begin
                            out_bit_d = par_q;
                        end else begin
                            out_bit_d = 1'b1;
                            state_d   = StAck;
                        end
                    end
                end
            end
            StAck: begin
                if (tmr_q >= PKT_LAST) begin
                    ok_d    = 1'b0;
                    state_d = StRecover;
                end else begin
                    tmr_d = tmr_inc;
                    if (fall) begin
                        ok_d    = ~filt_q[1];
                        state_d = StRecover;
                    end
                end
            end
            StRecover: begin
                if (lines_idle) begin
                    tmr_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (reset_in) begin
            state_q   <= StIdle;
            tmr_q     <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            out_bit_q <= 1'b0;
            ok_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            par_q     <= par_d;
            out_bit_q <= out_bit_d;
            ok_q      <= ok_d;
        end
    end

    // Start bit is pulled low already in the final inhibit cycle.
    always_comb begin
        ps2_clk_oe  = (state_q == StInhibit);
        ps2_data_oe = 1'b0;
        unique case (state_q)
            StInhibit: ps2_data_oe = (tmr_q >= INH_LAST);
            StReq:     ps2_data_oe = 1'b1;
            StShift:   ps2_data_oe = ~out_bit_q;
            default:   ps2_data_oe = 1'b0;
        endcase
    end

    assign tx_busy    = (state_q != StIdle);
    assign rx_inhibit = tx_busy;
    assign tx_done    = (state_q == StRecover) & lines_idle &  ok_q & ~reset_in;
    assign tx_err     = (state_q == StRecover) & lines_idle & ~ok_q & ~reset_in;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 2500: clock-inhibit length in mclk cycles (100 us at 25 MHz).
REQ-002 SHALL have parameter START_TO, default 375000: cycles allowed from clock release to the first device falling edge (15 ms).
REQ-003 SHALL have parameter PKT_TO, default 50000: cycles allowed from the first falling edge to ACK (2 ms).
REQ-004 SHALL have parameter FILT, default 8: consecutive equal samples needed to accept a line level.
REQ-005 mclk  in  1  sole clock; all logic on its rising edge.
REQ-006 reset_in  in  1  synchronous, active-high reset.
REQ-007 ps2_clk_i  in  1  PS2_Clk pad level (asynchronous).
REQ-008 ps2_data_i  in  1  PS2_Data pad level (asynchronous).
REQ-009 ps2_clk_oe  out  1  1 = drive PS2_Clk low; 0 = release.
REQ-010 ps2_data_oe  out  1  1 = drive PS2_Data low; 0 = release.
REQ-011 tx_data  in  8  byte to send to the keyboard, LSB first.
REQ-012 tx_wr  in  1  one-cycle request; tx_data is captured in the same cycle.
REQ-013 tx_busy  out  1  high from the cycle after an accepted tx_wr until done or error.
REQ-014 tx_done  out  1  one-cycle pulse on good ACK.
REQ-015 tx_err  out  1  one-cycle pulse on timeout or missing ACK.
REQ-016 rx_inhibit  out  1  equals tx_busy; tells kbd_intf to ignore line activity.

Function
REQ-017 Each pad input SHALL pass a 2-flop synchronizer, then the FILT glitch filter; "fall" SHALL mean a one-cycle pulse when the filtered clock goes from 1 to 0.
REQ-018 The states SHALL be IDLE, INHIBIT, REQ, SHIFT, ACK, RECOVER.
REQ-019 IDLE: both oe=0 and tx_busy=0; tx_wr SHALL latch tx_data, compute odd parity (~^tx_data) and go to INHIBIT.
REQ-020 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYC cycles; in the last cycle ps2_data_oe SHALL go to 1; then go to REQ.
REQ-021 REQ: ps2_clk_oe=0 and ps2_data_oe=1 (start bit); the first fall SHALL go to SHIFT with bit counter = 0; START_TO cycles without a fall SHALL cause an error.
REQ-022 SHIFT: on each fall with counter n, drive frame bit n+1 and increment n. Frame: bits 1-8 = tx_data[0..7], bit 9 = parity, bit 10 = 1 (stop). ps2_data_oe = ~bit.
REQ-023 On the fall that drives the stop bit (n = 9), ps2_data_oe SHALL be 0 and the next state SHALL be ACK.
REQ-024 ACK: on the next fall, sample the filtered data. 0 SHALL go to RECOVER with a success flag; 1 SHALL go to RECOVER with an error flag.
REQ-025 The PKT_TO timer SHALL start on the first fall and cover both SHIFT and ACK; on expiry it SHALL raise an error.
REQ-026 RECOVER: wait until filtered clock and data are both 1, then go to IDLE and pulse tx_done (success) or tx_err (error) in that same cycle.
REQ-027 Any error SHALL immediately set both oe=0 and go to RECOVER; tx_err SHALL fire once, when the lines are idle.
REQ-028 tx_wr while tx_busy=1 SHALL be ignored, with no change to the latched byte or the state.
REQ-029 tx_done and tx_err SHALL never be high in the same cycle, and each SHALL last exactly one cycle.
REQ-030 Timers SHALL be free of wrap-around: each counter SHALL be at least ceil(log2(max parameter + 1)) bits wide and SHALL saturate.
REQ-031 A fall seen in IDLE or INHIBIT SHALL have no effect.

Reset
REQ-032 When reset_in=1, the next edge SHALL set state to IDLE, both oe=0, tx_busy=0, tx_done=0, tx_err=0, all counters=0 and the latched byte=0.
REQ-033 Reset asserted mid-frame SHALL release both lines within one cycle and SHALL not produce a done or error pulse.

Verification
REQ-034 Send tx_wr with 0xED and a device model using a 12.5 kHz clock and an ACK: line bits 0,1,0,1,1,0,1,1,1 then parity 1, stop 1; one tx_done pulse; no tx_err.
REQ-035 Send tx_wr with 0x00: parity bit = 1 on the line; a second tx_wr 3 cycles later is ignored, and the frame is unchanged.
REQ-036 Device never clocks: ps2_clk_oe is high for exactly 2500 cycles; tx_err pulses START_TO cycles after release; both oe=0.
REQ-037 Device holds data high in the ACK slot: tx_err pulses after the lines go idle; no tx_done.
REQ-038 Assert reset_in after the 4th fall: both oe=0 on the next edge; tx_busy=0; no pulses; a fresh tx_wr of 0xF4 then completes normally.
REQ-039 Inject 3-cycle glitches on ps2_clk_i during SHIFT: the bit counter is unaffected and the frame is still correct.
